// File: rtl/rs_branch_queue_if.sv
// Allocation, wakeup-broadcast and issue bus of the branch reservation queue.
// master = upstream/downstream environment, slave = rs_branch_queue.
interface rs_branch_queue_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned OP_W  = 6,
  parameter int unsigned NCDB  = 3
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic                   alloc_en;
  logic [XLEN-1:0]        alloc_pc;
  logic [XLEN-1:0]        alloc_imm;
  logic [XLEN-1:0]        alloc_datax;
  logic [XLEN-1:0]        alloc_datay;
  logic [OP_W-1:0]        alloc_op;
  logic [TAG_W-1:0]       alloc_tagx;
  logic [TAG_W-1:0]       alloc_tagy;
  logic                   full;
  logic [CNT_W-1:0]       count;

  logic [NCDB-1:0]        cdb_en;
  logic [NCDB*TAG_W-1:0]  cdb_tag;
  logic [NCDB*XLEN-1:0]   cdb_data;

  logic                   issue_valid;
  logic                   issue_ready;
  logic [XLEN-1:0]        issue_pc;
  logic [XLEN-1:0]        issue_offset;
  logic [XLEN-1:0]        issue_datax;
  logic [XLEN-1:0]        issue_datay;
  logic [OP_W-1:0]        issue_op;

  modport master (
    output alloc_en, alloc_pc, alloc_imm, alloc_datax, alloc_datay, alloc_op,
           alloc_tagx, alloc_tagy, cdb_en, cdb_tag, cdb_data, issue_ready,
    input  full, count, issue_valid, issue_pc, issue_offset, issue_datax,
           issue_datay, issue_op
  );

  modport slave (
    input  alloc_en, alloc_pc, alloc_imm, alloc_datax, alloc_datay, alloc_op,
           alloc_tagx, alloc_tagy, cdb_en, cdb_tag, cdb_data, issue_ready,
    output full, count, issue_valid, issue_pc, issue_offset, issue_datax,
           issue_datay, issue_op
  );
endinterface

// File: rtl/rs_branch_queue.sv
// Branch reservation station: operand wakeup from NCDB broadcast ports and a registered issue slot.
// Define RS_BRANCH_AGE_ORDER_EN to issue the oldest ready entry; otherwise the lowest-index ready entry issues.
module rs_branch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned OP_W  = 6,
  parameter int unsigned NCDB  = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  input  logic flush,
  rs_branch_queue_if.slave bus
);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  data;
  } opnd_t;

  logic [DEPTH-1:0] valid;
  logic [XLEN-1:0]  pc_q  [DEPTH];
  logic [XLEN-1:0]  imm_q [DEPTH];
  logic [XLEN-1:0]  dx_q  [DEPTH];
  logic [XLEN-1:0]  dy_q  [DEPTH];
  logic [OP_W-1:0]  op_q  [DEPTH];
  logic [TAG_W-1:0] tx_q  [DEPTH];
  logic [TAG_W-1:0] ty_q  [DEPTH];

  logic             issue_valid_q;
  logic [XLEN-1:0]  issue_pc_q;
  logic [XLEN-1:0]  issue_offset_q;
  logic [XLEN-1:0]  issue_datax_q;
  logic [XLEN-1:0]  issue_datay_q;
  logic [OP_W-1:0]  issue_op_q;

  logic [NCDB-1:0]       cdb_en;
  logic [NCDB*TAG_W-1:0] cdb_tag;
  logic [NCDB*XLEN-1:0]  cdb_data;

  assign cdb_en   = bus.cdb_en;
  assign cdb_tag  = bus.cdb_tag;
  assign cdb_data = bus.cdb_data;

  // Ports scanned high to low so the lowest matching port is the final writer.
  function automatic opnd_t wake(input logic [TAG_W-1:0]      tag,
                                 input logic [XLEN-1:0]       data,
                                 input logic [NCDB-1:0]       en,
                                 input logic [NCDB*TAG_W-1:0] tags,
                                 input logic [NCDB*XLEN-1:0]  datas);
    opnd_t r;
    r.tag  = tag;
    r.data = data;
    for (int unsigned p = NCDB; p > 0; p--) begin
      if (en[p-1] && (tag != '0) && (tags[(p-1)*TAG_W +: TAG_W] == tag)) begin
        r.tag  = '0;
        r.data = datas[(p-1)*XLEN +: XLEN];
      end
    end
    return r;
  endfunction

  opnd_t            wx [DEPTH];
  opnd_t            wy [DEPTH];
  opnd_t            ax;
  opnd_t            ay;
  logic [DEPTH-1:0] ready;
  logic [DEPTH-1:0] eligible;

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      wx[i]    = wake(tx_q[i], dx_q[i], cdb_en, cdb_tag, cdb_data);
      wy[i]    = wake(ty_q[i], dy_q[i], cdb_en, cdb_tag, cdb_data);
      ready[i] = valid[i] && (wx[i].tag == '0) && (wy[i].tag == '0);
    end
    ax = wake(bus.alloc_tagx, bus.alloc_datax, cdb_en, cdb_tag, cdb_data);
    ay = wake(bus.alloc_tagy, bus.alloc_datay, cdb_en, cdb_tag, cdb_data);
  end

`ifdef RS_BRANCH_AGE_ORDER_EN
  // older[i][j] set: entry i was allocated before entry j while both were live.
  logic [DEPTH-1:0] older [DEPTH];
  logic [DEPTH-1:0] blocked;

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      blocked[i] = 1'b0;
      for (int unsigned j = 0; j < DEPTH; j++) begin
        if (ready[j] && older[j][i]) blocked[i] = 1'b1;
      end
    end
    eligible = ready & ~blocked;
  end
`else
  assign eligible = ready;
`endif

  logic             has_free;
  logic [IDX_W-1:0] alloc_idx;
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic [CNT_W-1:0] cnt;

  always_comb begin
    has_free  = 1'b0;
    alloc_idx = '0;
    sel_found = 1'b0;
    sel_idx   = '0;
    cnt       = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!valid[i] && !has_free) begin
        has_free  = 1'b1;
        alloc_idx = IDX_W'(i);
      end
      if (eligible[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
      cnt = cnt + CNT_W'(valid[i]);
    end
    cnt = cnt + CNT_W'(issue_valid_q);
  end

  logic slot_free;
  logic do_issue;
  logic do_alloc;

  assign slot_free = !issue_valid_q || bus.issue_ready;
  assign do_issue  = slot_free && sel_found;
  assign do_alloc  = bus.alloc_en && has_free;

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid          <= '0;
      issue_valid_q  <= 1'b0;
      issue_pc_q     <= '0;
      issue_offset_q <= '0;
      issue_datax_q  <= '0;
      issue_datay_q  <= '0;
      issue_op_q     <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_q[i]  <= '0;
        imm_q[i] <= '0;
        dx_q[i]  <= '0;
        dy_q[i]  <= '0;
        op_q[i]  <= '0;
        tx_q[i]  <= '0;
        ty_q[i]  <= '0;
`ifdef RS_BRANCH_AGE_ORDER_EN
        older[i] <= '0;
`endif
      end
    end else if (rdy) begin
      if (flush) begin
        valid         <= '0;
        issue_valid_q <= 1'b0;
      end else begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          tx_q[i] <= wx[i].tag;
          dx_q[i] <= wx[i].data;
          ty_q[i] <= wy[i].tag;
          dy_q[i] <= wy[i].data;
        end

        if (do_issue) begin
          valid[sel_idx] <= 1'b0;
          issue_valid_q  <= 1'b1;
          issue_pc_q     <= pc_q[sel_idx];
          issue_offset_q <= imm_q[sel_idx];
          issue_op_q     <= op_q[sel_idx];
          issue_datax_q  <= wx[sel_idx].data;
          issue_datay_q  <= wy[sel_idx].data;
        end else if (bus.issue_ready) begin
          issue_valid_q <= 1'b0;
        end

        // alloc_idx is never a live entry, so it cannot collide with sel_idx.
        if (do_alloc) begin
          valid[alloc_idx] <= 1'b1;
          pc_q[alloc_idx]  <= bus.alloc_pc;
          imm_q[alloc_idx] <= bus.alloc_imm;
          op_q[alloc_idx]  <= bus.alloc_op;
          tx_q[alloc_idx]  <= ax.tag;
          dx_q[alloc_idx]  <= ax.data;
          ty_q[alloc_idx]  <= ay.tag;
          dy_q[alloc_idx]  <= ay.data;
`ifdef RS_BRANCH_AGE_ORDER_EN
          for (int unsigned j = 0; j < DEPTH; j++) begin
            older[alloc_idx][j] <= 1'b0;
            older[j][alloc_idx] <= valid[j];
          end
`endif
        end
      end
    end
  end

  assign bus.full         = !has_free;
  assign bus.count        = cnt;
  assign bus.issue_valid  = issue_valid_q;
  assign bus.issue_pc     = issue_pc_q;
  assign bus.issue_offset = issue_offset_q;
  assign bus.issue_datax  = issue_datax_q;
  assign bus.issue_datay  = issue_datay_q;
  assign bus.issue_op     = issue_op_q;

endmodule
